// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for
// the RV32I core. It owns the instruction register and drives all datapath
// selects, memory handshakes, PC-update strobes and the retire counter.
// Ports:
//   clk, rst                        clock, async active-high reset
//   instrMemReq/instrMemReady/instrIn  instruction fetch handshake
//   currInstr                       latched instruction register
//   dataMemReq/dataMemWe/dataMemReady  data memory handshake
//   branchTaken                     comparator result for current branch
//   aluSrcA/aluSrcB/aluOp           ALU operand selects and function
//   regWrite/wbSel                  regfile write strobe and source select
//   pcWrite/pcSel                   PC update strobe and source select
//   illegal                         sticky unsupported-opcode flag
//   state                           current sequencer state
//   instrRetired                    retired-instruction counter
module rv32i_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic        instrMemReq,
    input  logic        instrMemReady,
    input  logic [31:0] instrIn,
    output logic [31:0] currInstr,
    output logic        dataMemReq,
    output logic        dataMemWe,
    input  logic        dataMemReady,
    input  logic        branchTaken,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [3:0]  aluOp,
    output logic        regWrite,
    output logic [1:0]  wbSel,
    output logic        pcWrite,
    output logic [1:0]  pcSel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instrRetired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    state_t      cur;
    state_t      nxt;
    logic [31:0] ir;
    logic        ill;
    logic [31:0] ret_cnt;

    logic        fetch_req;
    logic        ld_ir;
    logic        set_ill;
    logic        retire;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_lui;
    logic        is_auipc;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_opimm;
    logic        is_op;
    logic        is_legal;
    logic        is_jump;

    assign opc       = ir[6:0];
    assign f3        = ir[14:12];
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_branch = (opc == 7'b1100011);
    assign is_load   = (opc == 7'b0000011);
    assign is_store  = (opc == 7'b0100011);
    assign is_opimm  = (opc == 7'b0010011);
    assign is_op     = (opc == 7'b0110011);
    assign is_jump   = is_jal | is_jalr;
    assign is_legal  = is_lui | is_auipc | is_jump | is_branch |
                       is_load | is_store | is_opimm | is_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= FETCH;
            ir      <= 32'd0;
            ill     <= 1'b0;
            ret_cnt <= 32'd0;
        end else begin
            cur <= nxt;
            if (ld_ir)
                ir <= instrIn;
            if (set_ill)
                ill <= 1'b1;
            if (retire)
                ret_cnt <= ret_cnt + 32'd1;
        end
    end

    always_comb begin
        nxt        = cur;
        fetch_req  = 1'b0;
        ld_ir      = 1'b0;
        set_ill    = 1'b0;
        retire     = 1'b0;
        dataMemReq = 1'b0;
        dataMemWe  = 1'b0;
        aluSrcA    = 2'd0;
        aluSrcB    = 2'd0;
        aluOp      = 4'd0;
        regWrite   = 1'b0;
        wbSel      = 2'd0;
        pcWrite    = 1'b0;
        pcSel      = 2'd0;
        case (cur)
            FETCH: begin
                fetch_req = 1'b1;
                if (instrMemReady) begin
                    ld_ir = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    nxt = EXEC;
                end else begin
                    set_ill = 1'b1;
                    nxt     = HALT;
                end
            end
            EXEC: begin
                unique case (1'b1)
                    is_op: begin
                        aluOp = {ir[30], f3};
                    end
                    is_opimm: begin
                        aluSrcB = 2'd1;
                        // only the shift-right pair uses funct7[5]
                        aluOp   = {(f3 == 3'b101) ? ir[30] : 1'b0, f3};
                    end
                    is_lui: begin
                        aluSrcA = 2'd2;
                        aluSrcB = 2'd1;
                    end
                    is_auipc, is_jal: begin
                        aluSrcA = 2'd1;
                        aluSrcB = 2'd1;
                    end
                    is_load, is_store, is_jalr: begin
                        aluSrcB = 2'd1;
                    end
                    is_branch: begin
                        aluOp = 4'b1000;
                    end
                    default: begin
                        aluOp = 4'd0;
                    end
                endcase
                if (is_load || is_store) begin
                    nxt = MEM;
                end else if (is_branch) begin
                    pcWrite = 1'b1;
                    pcSel   = branchTaken ? 2'd2 : 2'd0;
                    retire  = 1'b1;
                    nxt     = FETCH;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                dataMemReq = 1'b1;
                dataMemWe  = is_store;
                if (dataMemReady) begin
                    if (is_store) begin
                        pcWrite = 1'b1;
                        retire  = 1'b1;
                        nxt     = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end
            end
            WB: begin
                regWrite = 1'b1;
                wbSel    = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
                pcWrite  = 1'b1;
                pcSel    = is_jump ? 2'd1 : 2'd0;
                retire   = 1'b1;
                nxt      = FETCH;
            end
            HALT: begin
                nxt = HALT;
            end
            default: begin
                nxt = FETCH;
            end
        endcase
    end

    // reset forces FETCH asynchronously; mask its request while rst is held
    assign instrMemReq  = fetch_req & ~rst;
    assign currInstr    = ir;
    assign illegal      = ill;
    assign state        = cur;
    assign instrRetired = ret_cnt;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb_rv32i_multicycle_ctrl: self-checking bench for rv32i_multicycle_ctrl.
// Expected per-cycle output vectors are queued per scenario and popped each cycle.
module tb_rv32i_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrMemReq;
    logic        instrMemReady = 1'b0;
    logic [31:0] instrIn = 32'd0;
    logic [31:0] currInstr;
    logic        dataMemReq;
    logic        dataMemWe;
    logic        dataMemReady = 1'b0;
    logic        branchTaken = 1'b0;
    logic [1:0]  aluSrcA;
    logic [1:0]  aluSrcB;
    logic [3:0]  aluOp;
    logic        regWrite;
    logic [1:0]  wbSel;
    logic        pcWrite;
    logic [1:0]  pcSel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instrRetired;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ret = 32'd0;
    logic [20:0] q[$];
    logic [20:0] e;
    logic [20:0] obs;

    rv32i_multicycle_ctrl dut (
        .clk(clk),
        .rst(rst),
        .instrMemReq(instrMemReq),
        .instrMemReady(instrMemReady),
        .instrIn(instrIn),
        .currInstr(currInstr),
        .dataMemReq(dataMemReq),
        .dataMemWe(dataMemWe),
        .dataMemReady(dataMemReady),
        .branchTaken(branchTaken),
        .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB),
        .aluOp(aluOp),
        .regWrite(regWrite),
        .wbSel(wbSel),
        .pcWrite(pcWrite),
        .pcSel(pcSel),
        .illegal(illegal),
        .state(state),
        .instrRetired(instrRetired)
    );

    always #5 clk = ~clk;

    assign obs = {state, instrMemReq, dataMemReq, dataMemWe, aluSrcA,
                  aluSrcB, aluOp, regWrite, wbSel, pcWrite, pcSel, illegal};

    function automatic logic [20:0] ev(
        input logic [2:0] st, input logic imr, input logic dmr,
        input logic dwe, input logic [1:0] sa, input logic [1:0] sbs,
        input logic [3:0] op, input logic rw, input logic [1:0] wb,
        input logic pw, input logic [1:0] ps, input logic ill);
        return {st, imr, dmr, dwe, sa, sbs, op, rw, wb, pw, ps, ill};
    endfunction

    // applies one cycle of stimulus at the falling edge, settles 1 time unit
    task automatic cyc(input logic imr, input logic dmr, input logic bt,
                       input logic [31:0] iw);
        @(negedge clk);
        instrMemReady = imr;
        dataMemReady  = dmr;
        branchTaken   = bt;
        instrIn       = iw;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        instrMemReady = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (obs !== 21'd0 || currInstr !== 32'd0 || instrRetired !== 32'd0) begin
            fails++;
            $display("FAIL reset_hold: got %h/%h/%h want 0/0/0",
                     obs, currInstr, instrRetired);
        end
        @(negedge clk);
        rst = 1'b0;
        instrMemReady = 1'b0;
        #1;
        tests++;
        if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
            fails++;
            $display("FAIL reset_release: got %h want %h",
                     obs, ev(0,1,0,0,0,0,0,0,0,0,0,0));
        end
    endtask

    task automatic test_alu_classes;
        logic [31:0] w [9] = '{32'h00500093, 32'hC0000093, 32'h4030D093,
                               32'h40208133, 32'h0020A133, 32'h123450B7,
                               32'h00001097, 32'h008000EF, 32'h000080E7};
        logic [1:0]  sa [9] = '{0, 0, 0, 0, 0, 2, 1, 1, 0};
        logic [1:0]  sbs[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
        logic [3:0]  op [9] = '{4'h0, 4'h0, 4'hD, 4'h8, 4'h2,
                                4'h0, 4'h0, 4'h0, 4'h0};
        logic [1:0]  wb [9] = '{0, 0, 0, 0, 0, 0, 0, 2, 2};
        logic [1:0]  ps [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 9; k++) begin
            q.push_back(ev(0,1,0,0,0,0,0,0,0,0,0,0));
            q.push_back(ev(1,0,0,0,0,0,0,0,0,0,0,0));
            q.push_back(ev(2,0,0,0,sa[k],sbs[k],op[k],0,0,0,0,0));
            q.push_back(ev(4,0,0,0,0,0,0,1,wb[k],1,ps[k],0));
            for (int c = 0; c < 4; c++) begin
                // ready held high throughout; only the FETCH word may load
                cyc(1'b1, 1'b0, 1'b0, (c == 0) ? w[k] : 32'hFFFF_FFFF);
                e = q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL alu_%0d_c%0d: got %h want %h", k, c, obs, e);
                end
            end
            tests++;
            if (currInstr !== w[k]) begin
                fails++;
                $display("FAIL ir_%0d: got %h want %h", k, currInstr, w[k]);
            end
            exp_ret = exp_ret + 32'd1;
            @(posedge clk);
            #1;
            tests++;
            if (instrRetired !== exp_ret || state !== 3'd0) begin
                fails++;
                $display("FAIL retire_%0d: got %0d/%0d want %0d/0",
                         k, instrRetired, state, exp_ret);
            end
        end
    endtask

    task automatic test_load;
        q.push_back(ev(0,1,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(1,0,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(2,0,0,0,0,1,0,0,0,0,0,0));
        for (int c = 0; c < 4; c++)
            q.push_back(ev(3,0,1,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(4,0,0,0,0,0,0,1,1,1,0,0));
        for (int c = 0; c < 8; c++) begin
            cyc(c == 0, c == 6, 1'b0, 32'h0000A103);
            e = q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL lw_c%0d: got %h want %h", c, obs, e);
            end
        end
        exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1;
        tests++;
        if (instrRetired !== exp_ret || state !== 3'd0) begin
            fails++;
            $display("FAIL lw_retire: got %0d/%0d want %0d/0",
                     instrRetired, state, exp_ret);
        end
    endtask

    task automatic test_store;
        for (int c = 0; c < 3; c++)
            q.push_back(ev(0,1,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(1,0,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(2,0,0,0,0,1,0,0,0,0,0,0));
        q.push_back(ev(3,0,1,1,0,0,0,0,0,0,0,0));
        q.push_back(ev(3,0,1,1,0,0,0,0,0,1,0,0));
        for (int c = 0; c < 7; c++) begin
            cyc(c == 2, c == 6, 1'b0, (c == 2) ? 32'h0020A023 : 32'd0);
            e = q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL sw_c%0d: got %h want %h", c, obs, e);
            end
        end
        exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1;
        tests++;
        if (instrRetired !== exp_ret || state !== 3'd0) begin
            fails++;
            $display("FAIL sw_retire: got %0d/%0d want %0d/0",
                     instrRetired, state, exp_ret);
        end
    endtask

    task automatic test_branch;
        for (int t = 0; t < 2; t++) begin
            q.push_back(ev(0,1,0,0,0,0,0,0,0,0,0,0));
            q.push_back(ev(1,0,0,0,0,0,0,0,0,0,0,0));
            q.push_back(ev(2,0,0,0,0,0,4'b1000,0,0,1,(t == 0) ? 2'd2 : 2'd0,0));
            for (int c = 0; c < 3; c++) begin
                cyc(c == 0, 1'b0, t == 0, 32'h00208463);
                e = q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL beq_t%0d_c%0d: got %h want %h", t, c, obs, e);
                end
            end
            exp_ret = exp_ret + 32'd1;
            @(posedge clk);
            #1;
            tests++;
            if (instrRetired !== exp_ret || state !== 3'd0) begin
                fails++;
                $display("FAIL beq_retire_%0d: got %0d/%0d want %0d/0",
                         t, instrRetired, state, exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid_mem;
        q.push_back(ev(0,1,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(1,0,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(2,0,0,0,0,1,0,0,0,0,0,0));
        q.push_back(ev(3,0,1,1,0,0,0,0,0,0,0,0));
        q.push_back(ev(3,0,1,1,0,0,0,0,0,0,0,0));
        for (int c = 0; c < 5; c++) begin
            cyc(c == 0, 1'b0, 1'b0, 32'h0020A023);
            e = q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL rstmem_c%0d: got %h want %h", c, obs, e);
            end
        end
        tests++;
        if (instrRetired !== exp_ret) begin
            fails++;
            $display("FAIL rstmem_wait_ret: got %0d want %0d",
                     instrRetired, exp_ret);
        end
        @(negedge clk);
        rst = 1'b1;
        dataMemReady = 1'b1;
        #1;
        exp_ret = 32'd0;
        tests++;
        if (obs !== 21'd0 || instrRetired !== exp_ret || currInstr !== 32'd0) begin
            fails++;
            $display("FAIL rstmem_abort: got %h/%0d/%h want 0/0/0",
                     obs, instrRetired, currInstr);
        end
        @(negedge clk);
        rst = 1'b0;
        dataMemReady = 1'b0;
        #1;
        tests++;
        if (obs !== ev(0,1,0,0,0,0,0,0,0,0,0,0) || instrRetired !== exp_ret) begin
            fails++;
            $display("FAIL rstmem_release: got %h/%0d want %h/0",
                     obs, instrRetired, ev(0,1,0,0,0,0,0,0,0,0,0,0));
        end
    endtask

    task automatic test_illegal;
        q.push_back(ev(0,1,0,0,0,0,0,0,0,0,0,0));
        q.push_back(ev(1,0,0,0,0,0,0,0,0,0,0,0));
        for (int c = 0; c < 5; c++)
            q.push_back(ev(7,0,0,0,0,0,0,0,0,0,0,1));
        for (int c = 0; c < 7; c++) begin
            // ready stays high after the fetch; HALT must not react to it
            cyc(1'b1, 1'b1, 1'b0, (c == 0) ? 32'h00000000 : 32'h00500093);
            e = q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL illegal_c%0d: got %h want %h", c, obs, e);
            end
        end
        tests++;
        if (instrRetired !== exp_ret || currInstr !== 32'd0) begin
            fails++;
            $display("FAIL illegal_hold: got %0d/%h want %0d/0",
                     instrRetired, currInstr, exp_ret);
        end
    endtask

    initial begin
        test_reset();
        test_alu_classes();
        test_load();
        test_store();
        test_branch();
        test_reset_mid_mem();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
